// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the fetch / load-store arbiter in front of a single-port byte RAM.
package mem_arbiter_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

    // Index of the last byte of an access; the reserved code 11 behaves as a word.
    function automatic logic [1:0] width_last(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 2'd0;
            WIDTH_HALF: return 2'd1;
            WIDTH_WORD: return 2'd3;
            default:    return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the arbiter; slave is the arbiter view, master the environment view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_width;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush, mem_req, mem_we, mem_width, mem_addr, mem_wdata, ram_din,
        output if_done, if_rdata, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout, busy
    );

    modport master (
        output if_req, if_addr, if_flush, mem_req, mem_we, mem_width, mem_addr, mem_wdata, ram_din,
        input  if_done, if_rdata, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout, busy
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto a single-port byte RAM, one byte per cycle.
//   state | meaning
//   IDLE  | sample requests, load/store wins over fetch
//   RD    | issue byte addresses, capture ram_din one cycle later
//   WR    | write one byte per cycle
//   DONE  | one-cycle done pulse to the granted port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    logic [1:0]        state_q;
    grant_t            gnt_q;
    logic              we_q;
    logic [1:0]        last_q;
    logic [1:0]        cnt_q;
    logic              tail_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic [1:0]        cap_idx;
    logic              flush_abort;

    assign flush_abort = (gnt_q == GNT_IF) && bus.if_flush &&
                         (state_q == ST_RD || state_q == ST_DONE);
    // RD spends one extra (tail) cycle so the byte addressed last can still be captured.
    assign cap_idx     = tail_q ? cnt_q : cnt_q - 2'd1;

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wr    = (state_q == ST_WR);
    assign bus.ram_dout  = (state_q == ST_WR) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
    assign bus.if_done   = (state_q == ST_DONE) && (gnt_q == GNT_IF) && !bus.if_flush;
    assign bus.mem_done  = (state_q == ST_DONE) && (gnt_q == GNT_MEM);
    assign bus.if_rdata  = bus.if_done ? buf_q : if_rdata_q;
    assign bus.mem_rdata = (bus.mem_done && !we_q) ? buf_q : mem_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_IF;
            we_q        <= 1'b0;
            last_q      <= 2'd0;
            cnt_q       <= 2'd0;
            tail_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.mem_req || bus.if_req) begin
                        gnt_q   <= bus.mem_req ? GNT_MEM : GNT_IF;
                        we_q    <= bus.mem_req && bus.mem_we;
                        last_q  <= bus.mem_req ? width_last(bus.mem_width) : 2'd3;
                        addr_q  <= bus.mem_req ? bus.mem_addr : bus.if_addr;
                        wdata_q <= bus.mem_wdata;
                        cnt_q   <= 2'd0;
                        tail_q  <= 1'b0;
                        buf_q   <= '0;
                        state_q <= (bus.mem_req && bus.mem_we) ? ST_WR : ST_RD;
                    end
                end
                ST_RD: begin
                    if (flush_abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        if (tail_q || cnt_q != 2'd0)
                            buf_q[{cap_idx, 3'b000} +: 8] <= bus.ram_din;
                        if (tail_q) begin
                            state_q <= ST_DONE;
                        end else if (cnt_q == last_q) begin
                            tail_q <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q + 2'd1;
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_WR: begin
                    if (cnt_q == last_q) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q  <= cnt_q + 2'd1;
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 2'd0;
                    tail_q  <= 1'b0;
                    if (bus.if_done)
                        if_rdata_q <= buf_q;
                    if (bus.mem_done && !we_q)
                        mem_rdata_q <= buf_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed corner cases followed by random fetch/load/store traffic.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic seed;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_mem;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    logic [7:0]  ram_mem [0:4095];
    logic [7:0]  gold    [0:4095];
    logic [31:0] last_if;
    logic [31:0] last_mem;

    // RAM aliases every 4 KiB; the reference memory uses the same folding.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (seed) begin
            for (int i = 0; i < 4096; i++) ram_mem[i] <= gold[i];
        end else if (bus.ram_wr) begin
            ram_mem[bus.ram_addr[11:0]] <= bus.ram_dout;
        end
        bus.ram_din <= ram_mem[bus.ram_addr[11:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        wr_t  w;
        if (rst) begin
            if (bus.if_done || bus.mem_done) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: if_done=%0b mem_done=%0b nothing outstanding (cycle %0d)",
                             bus.if_done, bus.mem_done, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("done_port_mem", {31'b0, bus.mem_done}, {31'b0, e.is_mem});
                    check("done_port_if", {31'b0, bus.if_done}, {31'b0, !e.is_mem});
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.chk_data)
                        check(e.is_mem ? "mem_rdata" : "if_rdata",
                              e.is_mem ? bus.mem_rdata : bus.if_rdata, e.data);
                end
            end
            if (bus.ram_wr) begin
                if (wr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %h data %h (cycle %0d)", bus.ram_addr, bus.ram_dout, cyc);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", bus.ram_addr, w.addr);
                    check("wr_data", {24'b0, bus.ram_dout}, {24'b0, w.data});
                end
            end else begin
                check("ram_dout_idle", {24'b0, bus.ram_dout}, 32'h0);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", k);
        end
    endtask

    task automatic wait_done(input bit is_mem);
        int k = 0;
        while (!(is_mem ? bus.mem_done : bus.if_done) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!(is_mem ? bus.mem_done : bus.if_done)) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: no %s done after %0d cycles", is_mem ? "mem" : "if", k);
        end
    endtask

    // Reference model: apply the access to the golden memory and predict the response.
    task automatic push_model(input bit is_mem, input bit we, input logic [1:0] w,
                              input logic [31:0] a, input logic [31:0] wd, input int extra);
        int          n;
        logic [31:0] ak;
        logic [31:0] d;
        exp_t        e;
        d = '0;
        n = (!is_mem || w[1]) ? 4 : (w[0] ? 2 : 1);
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            if (is_mem && we) begin
                gold[ak[11:0]] = wd[8*k +: 8];
                wr_q.push_back('{addr: ak, data: wd[8*k +: 8]});
            end else begin
                d[8*k +: 8] = gold[ak[11:0]];
            end
        end
        e.is_mem   = is_mem;
        e.chk_data = !(is_mem && we);
        e.data     = d;
        e.cyc      = cyc + n + ((is_mem && we) ? 1 : 2) + extra;
        exp_q.push_back(e);
        if (!is_mem)  last_if  = d;
        else if (!we) last_mem = d;
    endtask

    task automatic drive(input bit is_mem, input bit we, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd);
        if (is_mem) begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we;
            bus.mem_width = w;
            bus.mem_addr  = a;
            bus.mem_wdata = wd;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = a;
        end
    endtask

    task automatic issue(input bit is_mem, input bit we, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd);
        wait_idle();
        push_model(is_mem, we, w, a, wd, 0);
        drive(is_mem, we, w, a, wd);
        wait_done(is_mem);
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b0;
        @(negedge clk);
        check("hold_if_rdata", bus.if_rdata, last_if);
        check("hold_mem_rdata", bus.mem_rdata, last_mem);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        int          kind;

        rst = 1'b0;
        seed = 1'b0;
        bus.if_req = 1'b0;    bus.if_addr = '0;   bus.if_flush = 1'b0;
        bus.mem_req = 1'b0;   bus.mem_we = 1'b0;  bus.mem_width = 2'b00;
        bus.mem_addr = '0;    bus.mem_wdata = '0;
        last_if = '0;
        last_mem = '0;
        for (int i = 0; i < 4096; i++) gold[i] = 8'($urandom);
        gold[12'h100] = 8'h13;
        gold[12'h101] = 8'h05;
        gold[12'h102] = 8'h10;
        gold[12'h103] = 8'h00;
        seed = 1'b1;
        repeat (3) @(negedge clk);
        seed = 1'b0;

        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_if_done", {31'b0, bus.if_done}, 32'h0);
        check("rst_mem_done", {31'b0, bus.mem_done}, 32'h0);
        check("rst_ram_wr", {31'b0, bus.ram_wr}, 32'h0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_mem_rdata", bus.mem_rdata, 32'h0);
        check("rst_ram_addr", bus.ram_addr, 32'h0);
        check("rst_ram_dout", {24'b0, bus.ram_dout}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Basic fetch of a known instruction word.
        issue(1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
        check("fetch_word", bus.if_rdata, 32'h0010_0513);

        // Simultaneous fetch and load: load first, fetch after one idle cycle.
        wait_idle();
        push_model(1'b1, 1'b0, 2'b10, 32'h200, 32'h0, 0);
        push_model(1'b0, 1'b0, 2'b10, 32'h104, 32'h0, 7);
        drive(1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
        drive(1'b0, 1'b0, 2'b10, 32'h104, 32'h0);
        wait_done(1'b1);
        bus.mem_req = 1'b0;
        wait_done(1'b0);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Unaligned half store crossing 0x3FF/0x400, then read back one byte.
        issue(1'b1, 1'b1, 2'b01, 32'h3FF, 32'h0000_BEEF);
        issue(1'b1, 1'b0, 2'b00, 32'h400, 32'h0);
        check("byte_load_be", bus.mem_rdata, 32'h0000_00BE);

        // Flush during RD: aborted, no if_done, if_rdata unchanged.
        wait_idle();
        drive(1'b0, 1'b0, 2'b10, 32'h40, 32'h0);
        repeat (3) @(negedge clk);
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        @(negedge clk);
        check("flush_rd_busy", {31'b0, bus.busy}, 32'h0);
        check("flush_rd_if_rdata", bus.if_rdata, last_if);
        bus.if_flush = 1'b0;
        repeat (3) @(negedge clk);

        // Flush during DONE suppresses the pulse and the data update.
        wait_idle();
        drive(1'b0, 1'b0, 2'b10, 32'h44, 32'h0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        @(negedge clk);
        check("flush_done_if_rdata", bus.if_rdata, last_if);
        @(negedge clk);
        check("flush_done_busy", {31'b0, bus.busy}, 32'h0);
        bus.if_flush = 1'b0;
        @(negedge clk);

        // if_flush has no effect on a load/store grant.
        bus.if_flush = 1'b1;
        issue(1'b1, 1'b0, 2'b10, 32'h80, 32'h0);
        bus.if_flush = 1'b0;

        // Reset in the middle of a word store: only byte 0 lands.
        wait_idle();
        a  = 32'h500;
        wd = 32'hA1B2_C3D4;
        gold[a[11:0]] = wd[7:0];
        wr_q.push_back('{addr: a, data: wd[7:0]});
        drive(1'b1, 1'b1, 2'b10, a, wd);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_ram_wr", {31'b0, bus.ram_wr}, 32'h0);
        check("rst_mid_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_mid_mem_done", {31'b0, bus.mem_done}, 32'h0);
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        last_if  = '0;
        last_mem = '0;
        check("rst_mid_writes_left", 32'(wr_q.size()), 32'h0);
        @(negedge clk);
        issue(1'b1, 1'b0, 2'b10, a, 32'h0);

        // Address wrap at the top of the address space.
        wait_idle();
        push_model(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, 0);
        drive(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0);
        a = 32'hFFFF_FFFE;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wrap_ram_addr", bus.ram_addr, a);
            a = a + 32'd1;
        end
        wait_done(1'b1);
        bus.mem_req = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           a = 32'($urandom_range(0, 2047));
            wd = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(kind != 0, kind == 2, 2'($urandom_range(0, 3)), a, wd);
        end

        repeat (3) @(negedge clk);
        check("outstanding_done", 32'(exp_q.size()), 32'h0);
        check("outstanding_writes", 32'(wr_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-004 if_req  input  1  instruction-fetch read request; always a 4-byte read.
REQ-005 if_addr  input  ADDR_W  fetch byte address.
REQ-006 if_flush  input  1  cancels an in-flight fetch (branch taken).
REQ-007 if_done  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 if_rdata  output  32  fetched word, little-endian.
REQ-009 mem_req  input  1  load/store request.
REQ-010 mem_we  input  1  1 = store, 0 = load.
REQ-011 mem_width  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-012 mem_addr  input  ADDR_W  load/store byte address; no alignment check.
REQ-013 mem_wdata  input  32  store data; low bytes used for byte/half.
REQ-014 mem_done  output  1  one-cycle pulse: load/store complete.
REQ-015 mem_rdata  output  32  load data, zero-extended.
REQ-016 ram_addr  output  ADDR_W  byte address to shared single-port byte RAM.
REQ-017 ram_wr  output  1  RAM write strobe.
REQ-018 ram_dout  output  8  RAM write byte.
REQ-019 ram_din  input  8  RAM read byte, valid one cycle after ram_addr presented.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 FSM states IDLE, RD, WR, DONE; byte counter cnt (0..3), length n = 1/2/4 from width.
REQ-022 In IDLE, mem_req has priority over if_req; grant, base address, width, we, wdata latched at the sampling edge.
REQ-023 Read: ram_addr = base+k in grant-edge cycles +1..+n; ram_din captured into byte k of the result one cycle later; DONE entered after the last capture.
REQ-024 Read latency: done pulse in cycle T+n+2 for a request sampled in IDLE at cycle T (word = T+6).
REQ-025 Write: ram_wr = 1, ram_addr = base+k, ram_dout = wdata[8k+7:8k] in cycles T+1..T+n; DONE in T+n+1.
REQ-026 DONE lasts exactly one cycle, asserts the granted requester's done, then IDLE.
REQ-027 Requester drops or replaces req at the edge that samples done; arbiter re-evaluates requests in the following IDLE cycle, so back-to-back requests incur one idle cycle.
REQ-028 if_rdata/mem_rdata hold their last value until the next completion of that port; unused upper bytes of a byte/half load are 0.
REQ-029 Address addition wraps modulo 2^ADDR_W.
REQ-030 if_flush during an IF grant (RD or DONE): abort, next state IDLE, no if_done, if_rdata unchanged; if_flush ignored in IDLE and during MEM grants.
REQ-031 Stores are never aborted; ram_wr is 0 in all states except WR.
REQ-032 When ram_wr = 0, ram_addr holds its last value and ram_dout = 0.

Reset
REQ-033 On rst = 0: state IDLE, cnt 0, if_done 0, mem_done 0, ram_wr 0 immediately (asynchronous); if_rdata, mem_rdata, ram_addr, ram_dout = 0.
REQ-034 Reset mid-transfer discards the transfer without a done pulse; a partially written store remains partially written.

Structure
REQ-035 Width codes, state encodings and bus-width macros belong in the shared defines header.
REQ-036 Single module, one FSM plus byte datapath; no sub-module.

Verification
REQ-037 Reset, if_req=1, if_addr=0x100, RAM[0x100..0x103]=13 05 10 00 -> if_done at T+6, if_rdata=0x00100513.
REQ-038 if_req and mem_req (load word 0x200) raised same cycle -> MEM served first, mem_done at T+6, IF granted next IDLE, if_done 7 cycles later.
REQ-039 Store half 0xBEEF to 0x3FF -> ram_wr in 2 cycles: (0x3FF,EF),(0x400,BE); mem_done at T+3; load byte 0x400 returns 0x000000BE.
REQ-040 IF word read 0x40, if_flush at T+3 -> IDLE next cycle, no if_done, if_rdata unchanged.
REQ-041 rst=0 asserted mid-store word at cycle T+2 -> ram_wr 0 immediately, only byte 0 written, no mem_done, busy 0.
REQ-042 Load word at 0xFFFFFFFE -> ram_addr sequence FFFFFFFE, FFFFFFFF, 0, 1.
